stripe_frame_source: RTL

//  Synthetic zebra-crossing frame generator: the transmit end of the pixel

---
 rtl/stripe_frame_source.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stripe_frame_source.sv
// stripe_frame_source: synthetic raster generator of horizontal bright/dark
// bands on a valid/ready pixel stream. Stands in for the camera in simulation
// and on-board self-test.
// Optional build macro STRIPE_NOISE_EN: XORs x_data[1:0] with a 16-bit LFSR
// (taps 16,14,13,11) that is reseeded at every frame start.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for start
// STREAM | presenting pixels, counters advance on each transfer
module stripe_frame_source #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int W          = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         loop,
  input  logic [7:0]   stripe_period,
  input  logic [7:0]   stripe_on,
  input  logic [W-1:0] bright_lvl,
  input  logic [W-1:0] dark_lvl,
  output logic         x_valid,
  input  logic         x_ready,
  output logic [W-1:0] x_data,
  output logic         sof,
  output logic         eol,
  output logic         busy,
  output logic         frame_done,
  output logic [7:0]   stripes_emitted
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    phase_q, phase_d;
  logic [7:0]    period_q, period_d;
  logic [7:0]    on_q, on_d;
  logic [W-1:0]  bright_q, bright_d;
  logic [W-1:0]  dark_q, dark_d;
  logic [7:0]    scnt_q, scnt_d;
  logic [7:0]    stripes_q, stripes_d;
  logic          done_q, done_d;
  logic [15:0]   lfsr_q, lfsr_d;

  logic          xfer;
  logic [7:0]    eff_period;
  logic [7:0]    scnt_nxt;
  logic [W-1:0]  pix;

  assign xfer       = (state_q == STREAM) && x_ready;
  assign eff_period = (period_q == 8'd0) ? 8'd1 : period_q;
  assign pix        = (phase_q < on_q) ? bright_q : dark_q;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      phase_q   <= '0;
      period_q  <= '0;
      on_q      <= '0;
      bright_q  <= '0;
      dark_q    <= '0;
      scnt_q    <= '0;
      stripes_q <= '0;
      done_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      phase_q   <= phase_d;
      period_q  <= period_d;
      on_q      <= on_d;
      bright_q  <= bright_d;
      dark_q    <= dark_d;
      scnt_q    <= scnt_d;
      stripes_q <= stripes_d;
      done_q    <= done_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // Next-state: frame start latches config, transfers walk the raster.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    phase_d   = phase_q;
    period_d  = period_q;
    on_d      = on_q;
    bright_d  = bright_q;
    dark_d    = dark_q;
    scnt_d    = scnt_q;
    stripes_d = stripes_q;
    done_d    = 1'b0;
    lfsr_d    = lfsr_q;
    scnt_nxt  = scnt_q;

    // A bright band begins when the first pixel of a phase-0 row goes out.
    if ((col_q == '0) && (phase_q == 8'd0) && (on_q != 8'd0) && (scnt_q != 8'hFF))
      scnt_nxt = scnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = STREAM;
          col_d    = '0;
          row_d    = '0;
          phase_d  = '0;
          scnt_d   = '0;
          lfsr_d   = LFSR_SEED;
          period_d = stripe_period;
          on_d     = stripe_on;
          bright_d = bright_lvl;
          dark_d   = dark_lvl;
        end
      end
      STREAM: begin
        if (xfer) begin
          scnt_d = scnt_nxt;
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          if ((col_q == COL_LAST) && (row_q == ROW_LAST)) begin
            done_d    = 1'b1;
            stripes_d = scnt_nxt;
            col_d     = '0;
            row_d     = '0;
            phase_d   = '0;
            scnt_d    = '0;
            lfsr_d    = LFSR_SEED;
            if (loop) begin
              period_d = stripe_period;
              on_d     = stripe_on;
              bright_d = bright_lvl;
              dark_d   = dark_lvl;
            end else begin
              state_d = IDLE;
            end
          end else if (col_q == COL_LAST) begin
            col_d   = '0;
            row_d   = row_q + 1'b1;
            phase_d = (phase_q == eff_period - 8'd1) ? 8'd0 : phase_q + 8'd1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x_valid         = (state_q == STREAM);
  assign busy            = (state_q == STREAM);
  assign sof             = x_valid && (col_q == '0) && (row_q == '0);
  assign eol             = x_valid && (col_q == COL_LAST);
  assign frame_done      = done_q;
  assign stripes_emitted = stripes_q;

`ifdef STRIPE_NOISE_EN
  assign x_data = x_valid ? {pix[W-1:2], pix[1:0] ^ lfsr_q[1:0]} : '0;
`else
  assign x_data = x_valid ? pix : '0;
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;
`endif

endmodule
